// File: rtl/tl_beh_pkg.sv
// tl_beh_pkg: shared TileLink-UH opcodes, slave FSM states and burst sizing.
package tl_beh_pkg;
  localparam logic [2:0] PUT_FULL = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] GET = 3'd4;
  localparam logic [2:0] ACCESS_ACK = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;
  typedef enum logic [1:0] {IDLE, WDATA, DELAY, RESP} state_t;
  // Unsupported sizes (>6) collapse to a single beat so the response stays one beat.
  function automatic logic [3:0] beats_from_size(input logic [3:0] size);
    return (size <= 4'd3 || size > 4'd6) ? 4'd1 : 4'd1 << (size - 4'd3);
  endfunction
endpackage

// File: rtl/tl_beh_mem_array.sv
// tl_beh_mem_array: single-port 64-bit word array with byte enables and registered read.
module tl_beh_mem_array #(
  parameter int WORDS = 256,
  parameter int AW = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [7:0]    be,
  input  logic [63:0]   wdata,
  input  logic          re,
  output logic [63:0]   rdata
);
  logic [63:0] mem [WORDS];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++)
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/tl_slave_mem_beh.sv
// tl_slave_mem_beh: behavioural TileLink-UH memory slave, one transaction at a time.
import tl_beh_pkg::*;
module tl_slave_mem_beh #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int SOURCE_WIDTH = 2,
  parameter int SIZE_WIDTH = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int MEM_WORDS = 256,
  parameter int RESP_DELAY = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    tl_slave_a_ready,
  input  logic                    tl_slave_a_valid,
  input  logic [2:0]              tl_slave_a_bits_opcode,
  input  logic [2:0]              tl_slave_a_bits_param,
  input  logic [SIZE_WIDTH-1:0]   tl_slave_a_bits_size,
  input  logic [SOURCE_WIDTH-1:0] tl_slave_a_bits_source,
  input  logic [ADDR_WIDTH-1:0]   tl_slave_a_bits_address,
  input  logic [DATA_WIDTH/8-1:0] tl_slave_a_bits_mask,
  input  logic [DATA_WIDTH-1:0]   tl_slave_a_bits_data,
  input  logic                    tl_slave_a_bits_corrupt,
  input  logic                    tl_slave_d_ready,
  output logic                    tl_slave_d_valid,
  output logic [2:0]              tl_slave_d_bits_opcode,
  output logic [1:0]              tl_slave_d_bits_param,
  output logic [SIZE_WIDTH-1:0]   tl_slave_d_bits_size,
  output logic [SOURCE_WIDTH-1:0] tl_slave_d_bits_source,
  output logic [1:0]              tl_slave_d_bits_sink,
  output logic                    tl_slave_d_bits_denied,
  output logic [DATA_WIDTH-1:0]   tl_slave_d_bits_data,
  output logic                    tl_slave_d_bits_corrupt
);
  localparam int IW = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(8 * MEM_WORDS);
  localparam logic [3:0] DLAST = (RESP_DELAY > 0) ? 4'(RESP_DELAY - 1) : 4'd0;
  localparam state_t AFTER_A = (RESP_DELAY == 0) ? RESP : DELAY;
  state_t state;
  logic [2:0] op;
  logic [SIZE_WIDTH-1:0] size;
  logic [SOURCE_WIDTH-1:0] src;
  logic denied;
  logic [3:0] beats, beat, dcnt, rbeats, rlast, a_beats;
  logic [IW-1:0] base, a_idx, mem_addr;
  logic [ADDR_WIDTH-1:0] off;
  logic a_fire, d_fire, a_put, a_denied, we, re;
  logic [DATA_WIDTH-1:0] rdata;
  logic unused_ok;
  assign a_fire = tl_slave_a_valid & tl_slave_a_ready;
  assign d_fire = tl_slave_d_valid & tl_slave_d_ready;
  assign off = tl_slave_a_bits_address - BASE_ADDR;
  assign a_idx = off[IW+2:3];
  assign a_put = tl_slave_a_bits_opcode == PUT_FULL || tl_slave_a_bits_opcode == PUT_PARTIAL;
  assign a_denied = tl_slave_a_bits_address < BASE_ADDR || {1'b0, off} >= LIMIT
                 || !(tl_slave_a_bits_opcode inside {PUT_FULL, PUT_PARTIAL, GET})
                 || tl_slave_a_bits_size > SIZE_WIDTH'(6);
  assign a_beats = beats_from_size(tl_slave_a_bits_size);
  assign rbeats = (op == GET) ? beats : 4'd1;
  assign rlast = rbeats - 4'd1;
  assign unused_ok = ^{tl_slave_a_bits_param, off[2:0]};
  // One shared port: writes during A beats, reads prefetch the next D beat.
  always_comb begin
    mem_addr = (state == IDLE) ? a_idx : (state == WDATA) ? base + IW'(beat) : base + IW'(beat + 4'd1);
    we = reset && a_fire && !tl_slave_a_bits_corrupt
      && ((state == IDLE) ? a_put && !a_denied : !denied);
    re = reset && ((state == IDLE) ? a_fire && tl_slave_a_bits_opcode == GET
                                   : state == RESP && d_fire && beat != rlast);
  end
  tl_beh_mem_array #(.WORDS(MEM_WORDS)) u_mem (
    .clk(clock), .addr(mem_addr), .we(we), .be(tl_slave_a_bits_mask),
    .wdata(tl_slave_a_bits_data), .re(re), .rdata(rdata)
  );
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      op <= '0;
      size <= '0;
      src <= '0;
      denied <= 1'b0;
      beats <= '0;
      beat <= '0;
      dcnt <= '0;
      base <= '0;
    end else begin
      case (state)
        IDLE: if (a_fire) begin
          op <= tl_slave_a_bits_opcode;
          size <= tl_slave_a_bits_size;
          src <= tl_slave_a_bits_source;
          denied <= a_denied;
          beats <= a_beats;
          base <= a_idx;
          beat <= (a_put && a_beats > 4'd1) ? 4'd1 : 4'd0;
          state <= (a_put && a_beats > 4'd1) ? WDATA : AFTER_A;
        end
        WDATA: if (a_fire) begin
          beat <= (beat == beats - 4'd1) ? 4'd0 : beat + 4'd1;
          state <= (beat == beats - 4'd1) ? AFTER_A : WDATA;
        end
        DELAY: begin
          dcnt <= (dcnt == DLAST) ? 4'd0 : dcnt + 4'd1;
          state <= (dcnt == DLAST) ? RESP : DELAY;
        end
        RESP: if (d_fire) begin
          beat <= (beat == rlast) ? 4'd0 : beat + 4'd1;
          state <= (beat == rlast) ? IDLE : RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign tl_slave_a_ready = state == IDLE || state == WDATA;
  assign tl_slave_d_valid = state == RESP;
  assign tl_slave_d_bits_opcode = (op == GET) ? ACCESS_ACK_DATA : ACCESS_ACK;
  assign tl_slave_d_bits_param = 2'd0;
  assign tl_slave_d_bits_size = size;
  assign tl_slave_d_bits_source = src;
  assign tl_slave_d_bits_sink = 2'd0;
  assign tl_slave_d_bits_denied = denied;
  assign tl_slave_d_bits_data = (op == GET && !denied) ? rdata : '0;
  assign tl_slave_d_bits_corrupt = denied && op == GET;
endmodule

// File: tb/tb_tl_slave_mem_beh.sv
// tb_tl_slave_mem_beh: directed scenario checks for the behavioural TileLink memory slave.
module tb_tl_slave_mem_beh;
  logic clock = 1'b0, reset = 1'b0;
  logic a_ready, a_valid = 0, a_corrupt = 0, d_ready = 0, d_valid, d_denied, d_corrupt;
  logic [2:0] a_opcode = 0, a_param = 0, d_opcode;
  logic [3:0] a_size = 0, d_size;
  logic [1:0] a_source = 0, d_source, d_param, d_sink;
  logic [31:0] a_address = 0;
  logic [7:0] a_mask = 0;
  logic [63:0] a_data = 0, d_data;
  logic b_ready, b_valid = 0, bd_ready = 0, bd_valid, bd_denied, bd_corrupt;
  logic [2:0] bd_opcode;
  logic [3:0] bd_size;
  logic [1:0] bd_source, bd_param, bd_sink;
  logic [63:0] bd_data;
  int checks = 0, errors = 0;

  always #5 clock = ~clock;

  tl_slave_mem_beh u0 (
    .clock(clock), .reset(reset), .tl_slave_a_ready(a_ready), .tl_slave_a_valid(a_valid),
    .tl_slave_a_bits_opcode(a_opcode), .tl_slave_a_bits_param(a_param), .tl_slave_a_bits_size(a_size),
    .tl_slave_a_bits_source(a_source), .tl_slave_a_bits_address(a_address), .tl_slave_a_bits_mask(a_mask),
    .tl_slave_a_bits_data(a_data), .tl_slave_a_bits_corrupt(a_corrupt), .tl_slave_d_ready(d_ready),
    .tl_slave_d_valid(d_valid), .tl_slave_d_bits_opcode(d_opcode), .tl_slave_d_bits_param(d_param),
    .tl_slave_d_bits_size(d_size), .tl_slave_d_bits_source(d_source), .tl_slave_d_bits_sink(d_sink),
    .tl_slave_d_bits_denied(d_denied), .tl_slave_d_bits_data(d_data), .tl_slave_d_bits_corrupt(d_corrupt)
  );

  tl_slave_mem_beh #(.RESP_DELAY(3)) u1 (
    .clock(clock), .reset(reset), .tl_slave_a_ready(b_ready), .tl_slave_a_valid(b_valid),
    .tl_slave_a_bits_opcode(3'd4), .tl_slave_a_bits_param(3'd0), .tl_slave_a_bits_size(4'd3),
    .tl_slave_a_bits_source(2'd3), .tl_slave_a_bits_address(32'h8000_0000), .tl_slave_a_bits_mask(8'hFF),
    .tl_slave_a_bits_data(64'd0), .tl_slave_a_bits_corrupt(1'b0), .tl_slave_d_ready(bd_ready),
    .tl_slave_d_valid(bd_valid), .tl_slave_d_bits_opcode(bd_opcode), .tl_slave_d_bits_param(bd_param),
    .tl_slave_d_bits_size(bd_size), .tl_slave_d_bits_source(bd_source), .tl_slave_d_bits_sink(bd_sink),
    .tl_slave_d_bits_denied(bd_denied), .tl_slave_d_bits_data(bd_data), .tl_slave_d_bits_corrupt(bd_corrupt)
  );

  // Presents one A beat and returns #1 after the edge on which it was accepted.
  task automatic a_beat(input logic [2:0] op, input logic [3:0] sz, input logic [31:0] addr,
                        input logic [7:0] mask, input logic [63:0] data, input logic [1:0] src);
    a_valid = 1; a_opcode = op; a_size = sz; a_address = addr; a_mask = mask; a_data = data; a_source = src;
    for (int i = 0; i < 20 && !a_ready; i++) begin @(posedge clock); #1; end
    if (a_ready !== 1'b1) begin errors++; $display("FAIL a_ready_wait got %b exp 1", a_ready); end
    checks++;
    @(posedge clock); #1;
  endtask

  task automatic d_take();
    d_ready = 1; @(posedge clock); #1; d_ready = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    if (a_ready !== 1'b1) begin errors++; $display("FAIL rst_a_ready got %b exp 1", a_ready); end
    checks++;
    if (d_valid !== 1'b0) begin errors++; $display("FAIL rst_d_valid got %b exp 0", d_valid); end
    checks++;
    if ({d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt} !== '0) begin
      errors++; $display("FAIL rst_d_bits got %h/%h/%b exp all zero", d_opcode, d_data, d_denied);
    end
    checks++;
    reset = 1;
    @(posedge clock); #1;
  endtask

  task automatic test_put_get();
    a_beat(3'd0, 4'd3, 32'h8000_0010, 8'hFF, 64'h1122334455667788, 2'd2);
    a_valid = 0;
    if ({d_valid, d_opcode, d_source, d_denied} !== {1'b1, 3'd0, 2'd2, 1'b0}) begin
      errors++; $display("FAIL put_ack got v%b op%0d src%0d den%b exp v1 op0 src2 den0", d_valid, d_opcode, d_source, d_denied);
    end
    checks++;
    d_take();
    if ({d_valid, a_ready} !== 2'b01) begin errors++; $display("FAIL put_done got dv%b ar%b exp dv0 ar1", d_valid, a_ready); end
    checks++;
    a_beat(3'd4, 4'd3, 32'h8000_0010, 8'hFF, 64'd0, 2'd1);
    a_valid = 0;
    if (d_valid !== 1'b1) begin errors++; $display("FAIL get_latency got dv%b exp 1", d_valid); end
    checks++;
    if ({d_opcode, d_source, d_denied, d_corrupt} !== {3'd1, 2'd1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL get_bits got op%0d src%0d den%b cor%b exp op1 src1 den0 cor0", d_opcode, d_source, d_denied, d_corrupt);
    end
    checks++;
    if (d_data !== 64'h1122334455667788) begin errors++; $display("FAIL get_data got %h exp 1122334455667788", d_data); end
    checks++;
    d_take();
  endtask

  task automatic test_partial();
    a_beat(3'd1, 4'd3, 32'h8000_0010, 8'h0F, 64'hFFFFFFFF_AAAAAAAA, 2'd0);
    a_valid = 0;
    d_take();
    a_beat(3'd4, 4'd3, 32'h8000_0010, 8'hFF, 64'd0, 2'd0);
    a_valid = 0;
    if (d_data !== 64'h11223344AAAAAAAA) begin errors++; $display("FAIL partial_data got %h exp 11223344aaaaaaaa", d_data); end
    checks++;
    d_take();
  endtask

  task automatic test_burst();
    for (int k = 0; k < 8; k++) a_beat(3'd0, 4'd6, 32'h8000_0040, 8'hFF, 64'(k), 2'd3);
    a_valid = 0;
    if ({d_valid, d_opcode, d_size} !== {1'b1, 3'd0, 4'd6}) begin
      errors++; $display("FAIL burst_put_ack got v%b op%0d sz%0d exp v1 op0 sz6", d_valid, d_opcode, d_size);
    end
    checks++;
    d_take();
    a_beat(3'd4, 4'd6, 32'h8000_0040, 8'hFF, 64'd0, 2'd3);
    a_valid = 0;
    for (int k = 0; k < 8; k++) begin
      if ({d_valid, a_ready, d_opcode, d_data} !== {1'b1, 1'b0, 3'd1, 64'(k)}) begin
        errors++; $display("FAIL burst_beat%0d got v%b ar%b op%0d d%h exp v1 ar0 op1 d%0d", k, d_valid, a_ready, d_opcode, d_data, k);
      end
      checks++;
      @(posedge clock); #1;
      if ({d_valid, d_data} !== {1'b1, 64'(k)}) begin
        errors++; $display("FAIL burst_stall%0d got v%b d%h exp v1 d%0d", k, d_valid, d_data, k);
      end
      checks++;
      d_take();
    end
    if ({d_valid, a_ready} !== 2'b01) begin errors++; $display("FAIL burst_end got dv%b ar%b exp dv0 ar1", d_valid, a_ready); end
    checks++;
  endtask

  task automatic test_denied();
    a_beat(3'd0, 4'd3, 32'h8000_0000, 8'hFF, 64'h0123456789ABCDEF, 2'd0);
    a_valid = 0;
    d_take();
    a_beat(3'd4, 4'd3, 32'h7FFF_FFF8, 8'hFF, 64'd0, 2'd1);
    a_valid = 0;
    if ({d_valid, d_opcode, d_denied, d_corrupt, d_data} !== {1'b1, 3'd1, 1'b1, 1'b1, 64'd0}) begin
      errors++; $display("FAIL denied_get got v%b op%0d den%b cor%b d%h exp v1 op1 den1 cor1 d0", d_valid, d_opcode, d_denied, d_corrupt, d_data);
    end
    checks++;
    d_take();
    a_beat(3'd0, 4'd3, 32'h8000_0800, 8'hFF, 64'hDEADBEEFDEADBEEF, 2'd2);
    a_valid = 0;
    if ({d_valid, d_opcode, d_denied, d_corrupt} !== {1'b1, 3'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL denied_put got v%b op%0d den%b cor%b exp v1 op0 den1 cor0", d_valid, d_opcode, d_denied, d_corrupt);
    end
    checks++;
    d_take();
    a_beat(3'd4, 4'd3, 32'h8000_0000, 8'hFF, 64'd0, 2'd0);
    a_valid = 0;
    if (d_data !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL denied_nowrite got %h exp 0123456789abcdef", d_data); end
    checks++;
    d_take();
  endtask

  task automatic test_opcode();
    a_beat(3'd2, 4'd3, 32'h8000_0010, 8'hFF, 64'd5, 2'd1);
    a_valid = 0;
    if ({d_valid, d_opcode, d_denied, d_corrupt} !== {1'b1, 3'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL bad_opcode got v%b op%0d den%b cor%b exp v1 op0 den1 cor0", d_valid, d_opcode, d_denied, d_corrupt);
    end
    checks++;
    d_take();
    if (d_valid !== 1'b0) begin errors++; $display("FAIL bad_opcode_single got %b exp 0", d_valid); end
    checks++;
  endtask

  task automatic test_delay();
    b_valid = 1;
    @(posedge clock); #1;
    b_valid = 0;
    for (int i = 0; i < 3; i++) begin
      if (bd_valid !== 1'b0) begin errors++; $display("FAIL delay_early%0d got %b exp 0", i, bd_valid); end
      checks++;
      @(posedge clock); #1;
    end
    if ({bd_valid, bd_opcode, bd_source} !== {1'b1, 3'd1, 2'd3}) begin
      errors++; $display("FAIL delay_rise got v%b op%0d src%0d exp v1 op1 src3", bd_valid, bd_opcode, bd_source);
    end
    checks++;
    bd_ready = 1; @(posedge clock); #1; bd_ready = 0;
    if ({bd_valid, b_ready} !== 2'b01) begin errors++; $display("FAIL delay_done got dv%b ar%b exp dv0 ar1", bd_valid, b_ready); end
    checks++;
  endtask

  task automatic test_reset_midburst();
    for (int k = 0; k < 4; k++) a_beat(3'd0, 4'd6, 32'h8000_0080, 8'hFF, 64'h100 + 64'(k), 2'd0);
    a_data = 64'h104;
    reset = 0;
    #1;
    if ({d_valid, a_ready} !== 2'b01) begin errors++; $display("FAIL midburst_reset got dv%b ar%b exp dv0 ar1", d_valid, a_ready); end
    checks++;
    @(posedge clock); #1;
    a_valid = 0;
    reset = 1;
    @(posedge clock); #1;
    a_beat(3'd4, 4'd3, 32'h8000_0080, 8'hFF, 64'd0, 2'd1);
    a_valid = 0;
    if ({d_valid, d_data} !== {1'b1, 64'h100}) begin errors++; $display("FAIL midburst_beat0 got v%b d%h exp v1 d100", d_valid, d_data); end
    checks++;
    d_take();
    a_beat(3'd4, 4'd3, 32'h8000_0098, 8'hFF, 64'd0, 2'd1);
    a_valid = 0;
    if ({d_valid, d_data} !== {1'b1, 64'h103}) begin errors++; $display("FAIL midburst_beat3 got v%b d%h exp v1 d103", d_valid, d_data); end
    checks++;
    d_take();
  endtask

  initial begin
    test_reset();
    test_put_get();
    test_partial();
    test_burst();
    test_denied();
    test_opcode();
    test_delay();
    test_reset_midburst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
